// File: rtl/bf_seq_pkg.sv
// Shared types and widths for the beamformer control sequencer.
package bf_seq_pkg;
  localparam int SIG_AW = 11;
  localparam int SUM_AW = 10;
  localparam int IDX_W  = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DRAIN,
    BEAM,
    FLUSH,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    SLICE_IDLE = 2'd0,
    SLICE1     = 2'd1,
    SLICE2     = 2'd2,
    SLICE3     = 2'd3
  } slice_e;
endpackage

// File: rtl/bf_sequencer_if.sv
// Control bundle between the sequencer (master) and the beamformer datapath plus host (slave).
interface bf_sequencer_if;
  import bf_seq_pkg::*;

  logic              go;
  logic              filt_valid;
  logic              bf_data_good;
  logic              host_rd_en;
  logic [SUM_AW-1:0] host_rd_addr;
  logic [SIG_AW-1:0] signal_address;
  logic              signalinen;
  logic              filt_start;
  logic [SIG_AW-1:0] readin_address;
  logic              filter_bram_output_write_en;
  logic              output_read_en;
  logic              startbeamformer;
  logic [IDX_W-1:0]  sample_index;
  logic [1:0]        slice_state;
  logic [SUM_AW-1:0] sumout_address;
  logic              sumouten;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  go, filt_valid, bf_data_good, host_rd_en, host_rd_addr,
    output signal_address, signalinen, filt_start, readin_address,
           filter_bram_output_write_en, output_read_en, startbeamformer,
           sample_index, slice_state, sumout_address, sumouten, busy, done, err
  );

  modport slave (
    output go, filt_valid, bf_data_good, host_rd_en, host_rd_addr,
    input  signal_address, signalinen, filt_start, readin_address,
           filter_bram_output_write_en, output_read_en, startbeamformer,
           sample_index, slice_state, sumout_address, sumouten, busy, done, err
  );
endinterface

// File: rtl/bf_slice_gen.sv
// Four-phase word cadence: phase 0 reads the word, phases 1..3 select its 32-bit slices.
// sample_index is live during slices and holds its last value otherwise.
module bf_slice_gen
  import bf_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic [SIG_AW-1:0] word_i,
  output slice_e            slice_o,
  output logic              rd_en_o,
  output logic [IDX_W-1:0]  sample_index_o,
  output logic              word_done_o
);
  logic [1:0]       phase_q, phase_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  always_comb begin
    phase_d = en_i ? phase_q + 2'd1 : 2'd0;
    idx_d   = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (en_i && phase_q != 2'd0) begin
      idx_d = IDX_W'(word_i) * IDX_W'(3) + IDX_W'(phase_q) - IDX_W'(1);
    end
    slice_o        = en_i ? slice_e'(phase_q) : SLICE_IDLE;
    rd_en_o        = en_i && (phase_q == 2'd0);
    word_done_o    = en_i && (phase_q == 2'd3);
    sample_index_o = idx_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      phase_q <= 2'd0;
      idx_q   <= '0;
    end else begin
      phase_q <= phase_d;
      idx_q   <= idx_d;
    end
  end
endmodule

// File: rtl/bf_sequencer.sv
// Acquisition sequencer: signal RAM -> filter -> output RAM, output RAM -> beamformer slices, host readout.
// Define BF_SEQ_DRAIN_TIMEOUT_EN to abort a stalled DRAIN after DRAIN_TIMEOUT idle cycles and flag err.
module bf_sequencer
  import bf_seq_pkg::*;
#(
  parameter int SIG_DEPTH     = 2048,
  parameter int SUM_DEPTH     = 1024,
  parameter int FLUSH_CYCLES  = 8,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  bf_sequencer_if.master bus
);
`ifdef BF_SEQ_DRAIN_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif
  localparam int WR_W = SIG_AW + 1;
  localparam int FL_W = $clog2(FLUSH_CYCLES + 1);
  localparam int TO_W = $clog2(DRAIN_TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [SIG_AW-1:0] rd_cnt_q, rd_cnt_d;
  logic [WR_W-1:0]   wr_cnt_q, wr_cnt_d;
  logic [SUM_AW-1:0] sum_cnt_q, sum_cnt_d;
  logic [FL_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [TO_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic              err_q, err_d;
  logic              filt_start_q;
  logic              start_acq, beam_en, word_done, rd_en, wr_full, last_addr;
  slice_e            slice;
  logic [IDX_W-1:0]  sample_index;

  assign start_acq = (state_q == IDLE || state_q == DONE) && bus.go;
  assign beam_en   = (state_q == BEAM);
  assign wr_full   = (wr_cnt_q == WR_W'(SIG_DEPTH));
  assign last_addr = (rd_cnt_q == SIG_AW'(SIG_DEPTH - 1));

  bf_slice_gen u_slice_gen (
    .clk_i          (clk),
    .rst_i          (rst),
    .en_i           (beam_en),
    .clr_i          (start_acq),
    .word_i         (rd_cnt_q),
    .slice_o        (slice),
    .rd_en_o        (rd_en),
    .sample_index_o (sample_index),
    .word_done_o    (word_done)
  );

  always_comb begin
    state_d     = state_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    sum_cnt_d   = sum_cnt_q;
    flush_cnt_d = flush_cnt_q;
    idle_cnt_d  = '0;
    err_d       = err_q;
    bus.signal_address              = '0;
    bus.signalinen                  = 1'b0;
    bus.readin_address              = '0;
    bus.filter_bram_output_write_en = 1'b0;
    bus.output_read_en              = 1'b0;
    bus.startbeamformer             = 1'b0;
    bus.sumout_address              = '0;
    bus.sumouten                    = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (start_acq) begin
          state_d     = LOAD;
          rd_cnt_d    = '0;
          wr_cnt_d    = '0;
          sum_cnt_d   = '0;
          flush_cnt_d = '0;
          err_d       = 1'b0;
        end
      end
      LOAD: begin
        bus.signalinen     = 1'b1;
        bus.signal_address = rd_cnt_q;
        rd_cnt_d           = rd_cnt_q + 1'b1;
        if (last_addr) begin
          rd_cnt_d = '0;
          state_d  = DRAIN;
        end
      end
      DRAIN: begin
        idle_cnt_d = bus.filt_valid ? '0 : idle_cnt_q + 1'b1;
        if (wr_full) begin
          state_d = BEAM;
        end else if (TIMEOUT_EN && !bus.filt_valid &&
                     idle_cnt_q == TO_W'(DRAIN_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = BEAM;
        end
      end
      BEAM: begin
        bus.startbeamformer = 1'b1;
        bus.readin_address  = rd_cnt_q;
        bus.output_read_en  = rd_en;
        if (word_done) begin
          rd_cnt_d = rd_cnt_q + 1'b1;
          if (last_addr) begin
            rd_cnt_d = '0;
            state_d  = FLUSH;
          end
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 1'b1;
        if (flush_cnt_q == FL_W'(FLUSH_CYCLES - 1)) begin
          flush_cnt_d = '0;
          state_d     = DONE;
        end
      end
      default: ;
    endcase

    // Filter results land in the output RAM only while filling; a full RAM drops extras.
    if (state_q == LOAD || state_q == DRAIN) begin
      bus.readin_address              = wr_cnt_q[SIG_AW-1:0];
      bus.filter_bram_output_write_en = bus.filt_valid && !wr_full;
      if (bus.filt_valid && !wr_full) wr_cnt_d = wr_cnt_q + 1'b1;
    end

    if (state_q == BEAM || state_q == FLUSH) begin
      bus.sumout_address = sum_cnt_q;
      if (bus.bf_data_good) begin
        sum_cnt_d = (sum_cnt_q == SUM_AW'(SUM_DEPTH - 1)) ? '0 : sum_cnt_q + 1'b1;
      end
    end

    if (state_q == DONE) begin
      bus.sumout_address = bus.host_rd_addr;
      bus.sumouten       = bus.host_rd_en;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      sum_cnt_q    <= '0;
      flush_cnt_q  <= '0;
      idle_cnt_q   <= '0;
      err_q        <= 1'b0;
      filt_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      sum_cnt_q    <= sum_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      idle_cnt_q   <= idle_cnt_d;
      err_q        <= err_d;
      filt_start_q <= (state_q == LOAD);
    end
  end

  assign bus.filt_start   = filt_start_q;
  assign bus.sample_index = sample_index;
  assign bus.slice_state  = slice;
  assign bus.busy         = (state_q != IDLE) && (state_q != DONE);
  assign bus.done         = (state_q == DONE);
  assign bus.err          = err_q;
endmodule

// File: tb/tb_bf_sequencer.sv
// Directed bench for bf_sequencer with SIG_DEPTH=8, SUM_DEPTH=4, FLUSH_CYCLES=8, DRAIN_TIMEOUT=16.
module tb_bf_sequencer;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   nwr   = 0;
  int   n;
  logic       echo_en = 1'b0;
  logic [4:0] pipe    = '0;

  bf_sequencer_if bus ();

  bf_sequencer #(
    .SIG_DEPTH     (8),
    .SUM_DEPTH     (4),
    .FLUSH_CYCLES  (8),
    .DRAIN_TIMEOUT (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Filter stand-in: filt_valid follows filt_start by 5 cycles when echo is enabled.
  task automatic tick();
    @(posedge clk);
    #1;
    bus.filt_valid = pipe[4] & echo_en;
    pipe = {pipe[3:0], bus.filt_start};
    #1;
  endtask

  task automatic mon_wr();
    if (bus.filter_bram_output_write_en) begin
      chk("wr_addr", 32'(bus.readin_address), 32'(nwr));
      nwr++;
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.go = 1'b0; bus.filt_valid = 1'b0; bus.bf_data_good = 1'b0;
    bus.host_rd_en = 1'b0; bus.host_rd_addr = '0;
    tick(); tick();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_strobes", 32'({bus.signalinen, bus.filt_start, bus.filter_bram_output_write_en,
                            bus.output_read_en, bus.startbeamformer, bus.sumouten, bus.err}), 0);
    rst = 1'b0;

    // Nominal acquisition with go masked during LOAD
    echo_en = 1'b1;
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("load_addr", 32'(bus.signal_address), 32'(k));
      chk("load_en", 32'(bus.signalinen), 1);
      chk("filt_start", 32'(bus.filt_start), (k != 0) ? 1 : 0);
      mon_wr();
      if (k == 3) bus.go = 1'b1;
      tick();
      bus.go = 1'b0;
    end
    chk("drain_en", 32'(bus.signalinen), 0);
    chk("drain_fstart", 32'(bus.filt_start), 1);
    chk("drain_busy", 32'(bus.busy), 1);
    mon_wr();
    n = 0;
    while (!bus.startbeamformer && n < 50) begin
      tick();
      n++;
      if (!bus.startbeamformer) mon_wr();
    end
    chk("beam_entry", 32'(bus.startbeamformer), 1);
    chk("write_count", 32'(nwr), 8);

    for (int j = 0; j < 32; j++) begin
      bus.bf_data_good = (j >= 4 && j <= 9);
      chk("beam_on", 32'(bus.startbeamformer), 1);
      chk("beam_word", 32'(bus.readin_address), 32'(j / 4));
      chk("slice", 32'(bus.slice_state), 32'(j % 4));
      chk("out_rd_en", 32'(bus.output_read_en), (j % 4 == 0) ? 1 : 0);
      if (j % 4 != 0) chk("sample_idx", 32'(bus.sample_index), 32'(3 * (j / 4) + (j % 4) - 1));
      else if (j >= 4) chk("sample_hold", 32'(bus.sample_index), 32'(3 * (j / 4) - 1));
      if (j >= 4 && j <= 9) chk("sum_addr", 32'(bus.sumout_address), 32'((j - 4) % 4));
      tick();
    end
    bus.bf_data_good = 1'b0;

    for (int k = 0; k < 8; k++) begin
      chk("flush_bf_off", 32'(bus.startbeamformer), 0);
      chk("flush_busy", 32'(bus.busy), 1);
      chk("flush_sum_addr", 32'(bus.sumout_address), 2);
      tick();
    end
    chk("done", 32'(bus.done), 1);
    chk("done_busy", 32'(bus.busy), 0);
    chk("done_err", 32'(bus.err), 0);
    bus.host_rd_en = 1'b1; bus.host_rd_addr = 10'd5;
    #1;
    chk("host_addr", 32'(bus.sumout_address), 5);
    chk("host_en", 32'(bus.sumouten), 1);
    bus.host_rd_en = 1'b0;

    // Overflow: ten forced valids in DRAIN, echo off
    echo_en = 1'b0;
    nwr = 0;
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    chk("rerun_addr0", 32'(bus.signal_address), 0);
    repeat (8) tick();
    chk("ovf_in_drain", 32'(bus.busy && !bus.signalinen && !bus.startbeamformer), 1);
    for (int p = 1; p <= 10; p++) begin
      if (p > 1) tick();
      bus.filt_valid = 1'b1;
      #1;
      if (p <= 8) begin
        chk("ovf_wr", 32'(bus.filter_bram_output_write_en), 1);
        chk("ovf_addr", 32'(bus.readin_address), 32'(p - 1));
        nwr++;
      end else if (p == 9) begin
        chk("ovf_drop", 32'(bus.filter_bram_output_write_en), 0);
        chk("ovf_still_drain", 32'(bus.startbeamformer), 0);
      end else begin
        chk("ovf_beam_wr", 32'(bus.filter_bram_output_write_en), 0);
        chk("ovf_beam", 32'(bus.startbeamformer), 1);
      end
    end
    chk("ovf_count", 32'(nwr), 8);

    // Reset at BEAM word 3
    repeat (12) tick();
    chk("mid_word3", 32'(bus.readin_address), 3);
    chk("mid_phase0", 32'(bus.output_read_en), 1);
    rst = 1'b1;
    tick();
    chk("mid_rst_busy", 32'(bus.busy), 0);
    chk("mid_rst_strobes", 32'({bus.signalinen, bus.filt_start, bus.filter_bram_output_write_en,
                                bus.output_read_en, bus.startbeamformer, bus.sumouten, bus.done}), 0);
    chk("mid_rst_slice", 32'(bus.slice_state), 0);
    chk("mid_rst_idx", 32'(bus.sample_index), 0);
    rst = 1'b0;
    bus.go = 1'b1; tick(); bus.go = 1'b0;
    chk("restart_addr", 32'(bus.signal_address), 0);
    chk("restart_en", 32'(bus.signalinen), 1);
    tick();
    chk("restart_addr1", 32'(bus.signal_address), 1);

`ifdef BF_SEQ_DRAIN_TIMEOUT_EN
    repeat (7) tick();
    for (int p = 1; p <= 6; p++) begin
      if (p > 1) tick();
      bus.filt_valid = 1'b1;
      #1;
    end
    chk("to_no_err_yet", 32'(bus.err), 0);
    // This tick is the edge that captures the last valid; BEAM follows 16 edges later.
    tick();
    n = 0;
    while (!bus.startbeamformer && n < 100) begin
      tick();
      n++;
    end
    chk("to_edges", 32'(n), 16);
    chk("to_err", 32'(bus.err), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
